// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction-fetch / load-store memory arbiter.
package mem_arbiter_pkg;

   // Transaction state: IDLE (free), REQ (request on memory port), RSP (awaiting data)
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } state_t;

   // Which requester owns the current transaction
   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_t;

   // Consecutive LSU wins over a waiting IFU before the IFU is forced through
   localparam logic [1:0] STREAK_MAX = 2'd3;

endpackage

// File: rtl/mem_arb_sel.sv
// Arbitration decision and LSU win-streak counter for mem_arbiter.
module mem_arb_sel
   import mem_arbiter_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   arb_en,
   input  logic   if_req,
   input  logic   ls_req,
   output owner_t winner
);

   logic [1:0] streak;

   // LSU wins by default; a waiting IFU is let through once the streak saturates
   always_comb begin
      winner = OWN_IF;
      if (ls_req && !(if_req && (streak == STREAK_MAX))) begin
         winner = OWN_LS;
      end
   end

   // Streak counts LSU wins taken while the IFU was also waiting; changes only on arbitration
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         streak <= '0;
      end else if (arb_en) begin
         if ((winner == OWN_LS) && if_req) begin
            if (streak != STREAK_MAX) begin
               streak <= streak + 2'd1;
            end
         end else begin
            streak <= '0;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (IFU / LSU) arbiter onto a single-outstanding shared memory port.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              if_req_i,
   input  logic [AW-1:0]     if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DW-1:0]     if_rdata_o,

   input  logic              ls_req_i,
   input  logic              ls_we_i,
   input  logic [AW-1:0]     ls_addr_i,
   input  logic [DW-1:0]     ls_wdata_i,
   input  logic [DW/8-1:0]   ls_be_i,
   output logic              ls_gnt_o,
   output logic              ls_rvalid_o,
   output logic [DW-1:0]     ls_rdata_o,

   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [AW-1:0]     mem_addr_o,
   output logic [DW-1:0]     mem_wdata_o,
   output logic [DW/8-1:0]   mem_be_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DW-1:0]     mem_rdata_i,

   output logic              err_o
);

   state_t            state;
   state_t            state_nxt;
   owner_t            owner;
   owner_t            winner;
   logic              arb_take;

   logic              we_q;
   logic [AW-1:0]     addr_q;
   logic [DW-1:0]     wdata_q;
   logic [DW/8-1:0]   be_q;

   assign arb_take = (state == IDLE) && (if_req_i || ls_req_i);

   mem_arb_sel u_sel (
      .clk    (clk),
      .rst_n  (rst_n),
      .arb_en (arb_take),
      .if_req (if_req_i),
      .ls_req (ls_req_i),
      .winner (winner)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus handshake steering toward the current owner
   always_comb begin
      state_nxt   = state;
      mem_req_o   = 1'b0;
      if_gnt_o    = 1'b0;
      ls_gnt_o    = 1'b0;
      if_rvalid_o = 1'b0;
      ls_rvalid_o = 1'b0;
      case (state)
         IDLE: begin
            if (if_req_i || ls_req_i) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            mem_req_o = 1'b1;
            if (owner == OWN_IF) begin
               if_gnt_o = mem_gnt_i;
            end else begin
               ls_gnt_o = mem_gnt_i;
            end
            if (mem_gnt_i) begin
               state_nxt = RSP;
            end
         end
         RSP: begin
            if (owner == OWN_IF) begin
               if_rvalid_o = mem_rvalid_i;
            end else begin
               ls_rvalid_o = mem_rvalid_i;
            end
            if (mem_rvalid_i) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Latch the winner's transaction fields at arbitration; they hold until the next one
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner   <= OWN_IF;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else if (arb_take) begin
         owner <= winner;
         if (winner == OWN_LS) begin
            we_q    <= ls_we_i;
            addr_q  <= ls_addr_i;
            wdata_q <= ls_wdata_i;
            be_q    <= ls_be_i;
         end else begin
            we_q    <= 1'b0;
            addr_q  <= if_addr_i;
            wdata_q <= '0;
            be_q    <= '1;
         end
      end
   end

   // Sticky error: a response arriving when no transaction is waiting for one
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_o <= 1'b0;
      end else if (mem_rvalid_i && (state != RSP)) begin
         err_o <= 1'b1;
      end
   end

   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_be_o    = be_q;

   // Read data is only meaningful alongside the matching rvalid
   assign if_rdata_o = mem_rdata_i;
   assign ls_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter plus stall/reset/error sequences.
module tb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_gnt_o;
   logic        if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        ls_req_i;
   logic        ls_we_i;
   logic [31:0] ls_addr_i;
   logic [31:0] ls_wdata_i;
   logic [3:0]  ls_be_i;
   logic        ls_gnt_o;
   logic        ls_rvalid_o;
   logic [31:0] ls_rdata_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        err_o;

   int unsigned errors;
   int unsigned checks;

   mem_arbiter #(.AW(32), .DW(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_req_i     (if_req_i),
      .if_addr_i    (if_addr_i),
      .if_gnt_o     (if_gnt_o),
      .if_rvalid_o  (if_rvalid_o),
      .if_rdata_o   (if_rdata_o),
      .ls_req_i     (ls_req_i),
      .ls_we_i      (ls_we_i),
      .ls_addr_i    (ls_addr_i),
      .ls_wdata_i   (ls_wdata_i),
      .ls_be_i      (ls_be_i),
      .ls_gnt_o     (ls_gnt_o),
      .ls_rvalid_o  (ls_rvalid_o),
      .ls_rdata_o   (ls_rdata_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_be_o     (mem_be_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .err_o        (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n, ifr, lsr, gnt, rv;
      logic        mreq, mwe;
      logic [3:0]  mbe;
      logic [31:0] maddr;
      logic        ig, irv, lg, lrv, err;
   } vec_t;

   vec_t tbl [21];

   function automatic vec_t mk(logic r, logic ifr, logic lsr, logic gnt, logic rv,
                               logic mreq, logic mwe, logic [3:0] mbe, logic [31:0] maddr,
                               logic ig, logic irv, logic lg, logic lrv, logic err);
      vec_t v;
      v.rst_n = r;   v.ifr = ifr; v.lsr = lsr; v.gnt = gnt; v.rv = rv;
      v.mreq = mreq; v.mwe = mwe; v.mbe = mbe; v.maddr = maddr;
      v.ig = ig;     v.irv = irv; v.lg = lg;   v.lrv = lrv; v.err = err;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      if_req_i     = 1'b0;
      ls_req_i     = 1'b0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n        = 1'b0;
      if_addr_i    = 32'h100;
      ls_we_i      = 1'b1;
      ls_addr_i    = 32'h200;
      ls_wdata_i   = 32'h55AA55AA;
      ls_be_i      = 4'h3;
      mem_rdata_i  = 32'hDEADBEEF;
      idle_inputs();

      // Rows: IFU alone (0-4), then both requesting with immediate gnt/rvalid
      //           rst ifr lsr gnt rv  mreq mwe  mbe    maddr    ig irv lg lrv err
      tbl[0]  = mk(0,  0,  0,  0,  0,  0,   0,  4'h0, 32'h000, 0, 0,  0, 0,  0);
      tbl[1]  = mk(1,  1,  0,  0,  0,  0,   0,  4'h0, 32'h000, 0, 0,  0, 0,  0);
      tbl[2]  = mk(1,  1,  0,  1,  0,  1,   0,  4'hF, 32'h100, 1, 0,  0, 0,  0);
      tbl[3]  = mk(1,  0,  0,  0,  1,  0,   0,  4'hF, 32'h100, 0, 1,  0, 0,  0);
      tbl[4]  = mk(1,  0,  0,  0,  0,  0,   0,  4'hF, 32'h100, 0, 0,  0, 0,  0);
      tbl[5]  = mk(1,  1,  1,  0,  0,  0,   0,  4'hF, 32'h100, 0, 0,  0, 0,  0);
      tbl[6]  = mk(1,  1,  1,  1,  0,  1,   1,  4'h3, 32'h200, 0, 0,  1, 0,  0);
      tbl[7]  = mk(1,  1,  1,  0,  1,  0,   1,  4'h3, 32'h200, 0, 0,  0, 1,  0);
      tbl[8]  = mk(1,  1,  1,  0,  0,  0,   1,  4'h3, 32'h200, 0, 0,  0, 0,  0);
      tbl[9]  = mk(1,  1,  1,  1,  0,  1,   1,  4'h3, 32'h200, 0, 0,  1, 0,  0);
      tbl[10] = mk(1,  1,  1,  0,  1,  0,   1,  4'h3, 32'h200, 0, 0,  0, 1,  0);
      tbl[11] = mk(1,  1,  1,  0,  0,  0,   1,  4'h3, 32'h200, 0, 0,  0, 0,  0);
      tbl[12] = mk(1,  1,  1,  1,  0,  1,   1,  4'h3, 32'h200, 0, 0,  1, 0,  0);
      tbl[13] = mk(1,  1,  1,  0,  1,  0,   1,  4'h3, 32'h200, 0, 0,  0, 1,  0);
      tbl[14] = mk(1,  1,  1,  0,  0,  0,   1,  4'h3, 32'h200, 0, 0,  0, 0,  0);
      tbl[15] = mk(1,  1,  1,  1,  0,  1,   0,  4'hF, 32'h100, 1, 0,  0, 0,  0);
      tbl[16] = mk(1,  1,  1,  0,  1,  0,   0,  4'hF, 32'h100, 0, 1,  0, 0,  0);
      tbl[17] = mk(1,  1,  1,  0,  0,  0,   0,  4'hF, 32'h100, 0, 0,  0, 0,  0);
      tbl[18] = mk(1,  1,  1,  1,  0,  1,   1,  4'h3, 32'h200, 0, 0,  1, 0,  0);
      tbl[19] = mk(1,  1,  1,  0,  1,  0,   1,  4'h3, 32'h200, 0, 0,  0, 1,  0);
      tbl[20] = mk(1,  0,  0,  0,  0,  0,   1,  4'h3, 32'h200, 0, 0,  0, 0,  0);

      repeat (2) @(posedge clk);
      @(negedge clk);

      for (int i = 0; i < 21; i++) begin
         rst_n        = tbl[i].rst_n;
         if_req_i     = tbl[i].ifr;
         ls_req_i     = tbl[i].lsr;
         mem_gnt_i    = tbl[i].gnt;
         mem_rvalid_i = tbl[i].rv;
         #1;
         chk($sformatf("v%0d mem_req", i),   {31'd0, mem_req_o},   {31'd0, tbl[i].mreq});
         chk($sformatf("v%0d mem_we", i),    {31'd0, mem_we_o},    {31'd0, tbl[i].mwe});
         chk($sformatf("v%0d mem_be", i),    {28'd0, mem_be_o},    {28'd0, tbl[i].mbe});
         chk($sformatf("v%0d mem_addr", i),  mem_addr_o,           tbl[i].maddr);
         chk($sformatf("v%0d if_gnt", i),    {31'd0, if_gnt_o},    {31'd0, tbl[i].ig});
         chk($sformatf("v%0d if_rvalid", i), {31'd0, if_rvalid_o}, {31'd0, tbl[i].irv});
         chk($sformatf("v%0d ls_gnt", i),    {31'd0, ls_gnt_o},    {31'd0, tbl[i].lg});
         chk($sformatf("v%0d ls_rvalid", i), {31'd0, ls_rvalid_o}, {31'd0, tbl[i].lrv});
         chk($sformatf("v%0d err", i),       {31'd0, err_o},       {31'd0, tbl[i].err});
         if (tbl[i].mwe && tbl[i].mreq)
            chk($sformatf("v%0d mem_wdata", i), mem_wdata_o, 32'h55AA55AA);
         if (tbl[i].irv)
            chk($sformatf("v%0d if_rdata", i), if_rdata_o, 32'hDEADBEEF);
         if (tbl[i].lrv)
            chk($sformatf("v%0d ls_rdata", i), ls_rdata_o, 32'hDEADBEEF);
         @(negedge clk);
      end

      // Stall: LSU load held in REQ for 5 cycles; req dropped and inputs changed after latch
      ls_we_i    = 1'b0;
      ls_addr_i  = 32'h300;
      ls_wdata_i = 32'h12345678;
      ls_be_i    = 4'hC;
      ls_req_i   = 1'b1;
      @(negedge clk);
      ls_req_i   = 1'b0;
      ls_addr_i  = 32'h3FC;
      ls_be_i    = 4'h1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("stall%0d mem_req", k),   {31'd0, mem_req_o}, 32'd1);
         chk($sformatf("stall%0d mem_addr", k),  mem_addr_o,         32'h300);
         chk($sformatf("stall%0d mem_we", k),    {31'd0, mem_we_o},  32'd0);
         chk($sformatf("stall%0d mem_be", k),    {28'd0, mem_be_o},  32'hC);
         chk($sformatf("stall%0d mem_wdata", k), mem_wdata_o,        32'h12345678);
         chk($sformatf("stall%0d ls_gnt", k),    {31'd0, ls_gnt_o},  32'd0);
         @(negedge clk);
      end
      mem_gnt_i = 1'b1;
      #1;
      chk("stall6 mem_req", {31'd0, mem_req_o}, 32'd1);
      chk("stall6 mem_addr", mem_addr_o, 32'h300);
      chk("stall6 ls_gnt", {31'd0, ls_gnt_o}, 32'd1);
      chk("stall6 if_gnt", {31'd0, if_gnt_o}, 32'd0);
      @(negedge clk);
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hCAFEF00D;
      #1;
      chk("stall rsp mem_req", {31'd0, mem_req_o}, 32'd0);
      chk("stall rsp ls_rvalid", {31'd0, ls_rvalid_o}, 32'd1);
      chk("stall rsp ls_rdata", ls_rdata_o, 32'hCAFEF00D);
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      #1;
      chk("stall done mem_req", {31'd0, mem_req_o}, 32'd0);
      chk("stall done err", {31'd0, err_o}, 32'd0);
      @(negedge clk);

      // Reset while in RSP, then a late rvalid
      if_addr_i = 32'h140;
      if_req_i  = 1'b1;
      @(negedge clk);
      if_req_i  = 1'b0;
      mem_gnt_i = 1'b1;
      #1;
      chk("rstrsp if_gnt", {31'd0, if_gnt_o}, 32'd1);
      chk("rstrsp mem_addr", mem_addr_o, 32'h140);
      @(negedge clk);
      mem_gnt_i = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      rst_n        = 1'b1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h11112222;
      #1;
      chk("rstrsp post mem_req", {31'd0, mem_req_o}, 32'd0);
      chk("rstrsp post mem_addr", mem_addr_o, 32'h0);
      chk("rstrsp post mem_be", {28'd0, mem_be_o}, 32'h0);
      chk("rstrsp late if_rvalid", {31'd0, if_rvalid_o}, 32'd0);
      chk("rstrsp late ls_rvalid", {31'd0, ls_rvalid_o}, 32'd0);
      chk("rstrsp err before", {31'd0, err_o}, 32'd0);
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      #1;
      chk("rstrsp err set", {31'd0, err_o}, 32'd1);
      chk("rstrsp idle mem_req", {31'd0, mem_req_o}, 32'd0);
      @(negedge clk);

      // Clear, then rvalid pulse in IDLE; err sticks through a normal transaction
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("idlerv err cleared", {31'd0, err_o}, 32'd0);
      @(negedge clk);
      mem_rvalid_i = 1'b1;
      #1;
      chk("idlerv if_rvalid", {31'd0, if_rvalid_o}, 32'd0);
      chk("idlerv ls_rvalid", {31'd0, ls_rvalid_o}, 32'd0);
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("idlerv err hold%0d", k), {31'd0, err_o}, 32'd1);
         chk($sformatf("idlerv mem_req%0d", k), {31'd0, mem_req_o}, 32'd0);
         @(negedge clk);
      end
      if_addr_i = 32'h180;
      if_req_i  = 1'b1;
      @(negedge clk);
      if_req_i  = 1'b0;
      mem_gnt_i = 1'b1;
      #1;
      chk("idlerv txn if_gnt", {31'd0, if_gnt_o}, 32'd1);
      chk("idlerv txn mem_addr", mem_addr_o, 32'h180);
      @(negedge clk);
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h0BADCAFE;
      #1;
      chk("idlerv txn if_rvalid", {31'd0, if_rvalid_o}, 32'd1);
      chk("idlerv txn if_rdata", if_rdata_o, 32'h0BADCAFE);
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      #1;
      chk("idlerv txn err still", {31'd0, err_o}, 32'd1);
      chk("idlerv txn done mem_req", {31'd0, mem_req_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("final err cleared", {31'd0, err_o}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
